adc_data_transmit_pack: RTL and testbench

- Transmit-side counterpart of the ADC LVDS capture path. Accepts parallel 8-sample x 10-bit frames in the clk_div domain and buffers them in a small FIFO.
- Inserts a training pattern when commanded, then transposes each frame into 10 lane bytes for 8:1 output serializers. The transpose is bit-exact, so the capture path's realign stage reproduces the original samples.
- Used as an ADC emulator / loopback source for link bring-up and verification.

---
 rtl/adc_data_transmit_pack.sv | 154 +++++++++++++++
 tb/tb_adc_data_transmit_pack.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_data_transmit_pack.sv
// ADC emulator transmit packer: frame FIFO, training insertion and
// sample-to-lane transpose feeding ten 8:1 output serializers.
module adc_data_transmit_pack #(
  parameter int         FIFO_DEPTH   = 4,
  parameter int         TRAIN_CYCLES = 64,
  parameter logic [7:0] TRAIN_BYTE   = 8'hF0,
  parameter logic [9:0] IDLE_SAMPLE  = 10'h200
) (
  input  logic        clk_div,
  input  logic        rst_n,
  input  logic [79:0] s_data,
  input  logic        s_or,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        train_req,
  input  logic [7:0]  train_len,
  output logic [79:0] q_data,
  output logic [7:0]  q_or,
  output logic        q_is_data,
  output logic        training,
  output logic [15:0] underflow_cnt
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (TRAIN_CYCLES > 256) ? $clog2(TRAIN_CYCLES) : 8;

  typedef enum logic [1:0] {ST_RST, ST_TRAIN, ST_DATA} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [80:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop;

  logic             trn_p0, vld_p0, idl_p0;
  logic [79:0]      frame_p0;
  logic             or_p0;

  // Lane j carries bit j of every sample, earliest sample in the lane LSB.
  function automatic logic [79:0] transpose(input logic [79:0] f);
    logic [79:0] t;
    t = '0;
    for (int j = 0; j < 10; j++)
      for (int k = 0; k < 8; k++)
        t[8*j+k] = f[10*k+j];
    return t;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign s_ready = !full && (state != ST_RST);
  assign push    = s_valid && s_ready;
  assign pop     = (state == ST_DATA) && !empty;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RST: begin
        state_nxt = ST_TRAIN;
        cnt_nxt   = CNT_W'(TRAIN_CYCLES - 1);
      end
      ST_TRAIN: begin
        if (cnt == '0) state_nxt = ST_DATA;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ST_DATA: ;
      default: state_nxt = ST_RST;
    endcase
    // A new request wins over expiry and restarts an ongoing training run.
    if (train_req && (state != ST_RST)) begin
      state_nxt = ST_TRAIN;
      cnt_nxt   = (train_len == 8'd0) ? '0 : CNT_W'(train_len - 8'd1);
    end
  end

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_RST;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_div) begin
    if (push) mem[wr_ptr] <= {s_or, s_data};
  end

  // ---- stage p0: frame selection ----
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      trn_p0 <= 1'b0;
      vld_p0 <= 1'b0;
      idl_p0 <= 1'b0;
    end else begin
      trn_p0 <= (state == ST_TRAIN);
      vld_p0 <= pop;
      idl_p0 <= (state == ST_DATA) && empty;
    end
  end

  always_ff @(posedge clk_div) begin
    frame_p0 <= pop ? mem[rd_ptr][79:0] : {8{IDLE_SAMPLE}};
    or_p0    <= pop && mem[rd_ptr][80];
  end

  // ---- stage p1: transposed output register ----
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      q_data        <= '0;
      q_or          <= '0;
      q_is_data     <= 1'b0;
      training      <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      q_or      <= '0;
      q_is_data <= 1'b0;
      training  <= 1'b0;
      if (trn_p0) begin
        q_data   <= {10{TRAIN_BYTE}};
        training <= 1'b1;
      end else if (vld_p0 || idl_p0) begin
        q_data <= transpose(frame_p0);
        if (vld_p0) begin
          q_or      <= {8{or_p0}};
          q_is_data <= 1'b1;
        end else begin
          underflow_cnt <= sat_inc(underflow_cnt);
        end
      end else begin
        q_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_adc_data_transmit_pack.sv
// Scoreboard bench for adc_data_transmit_pack: stimulus pushes expected
// lane frames; a negedge monitor classifies and checks every output frame.
module tb_adc_data_transmit_pack;

  logic        clk_div = 1'b0;
  logic        rst_n;
  logic [79:0] s_data;
  logic        s_or;
  logic        s_valid;
  logic        s_ready;
  logic        train_req;
  logic [7:0]  train_len;
  logic [79:0] q_data;
  logic [7:0]  q_or;
  logic        q_is_data;
  logic        training;
  logic [15:0] underflow_cnt;

  always #5 clk_div = ~clk_div;

  adc_data_transmit_pack dut (
    .clk_div(clk_div), .rst_n(rst_n), .s_data(s_data), .s_or(s_or),
    .s_valid(s_valid), .s_ready(s_ready), .train_req(train_req),
    .train_len(train_len), .q_data(q_data), .q_or(q_or),
    .q_is_data(q_is_data), .training(training), .underflow_cnt(underflow_cnt)
  );

  localparam logic [79:0] TRAIN_Q = {10{8'hF0}};
  localparam logic [79:0] IDLE_Q  = 80'hFF000000000000000000;

  typedef struct {
    logic [79:0] src;
    logic [79:0] exp_q;
    logic        exp_or;
  } sb_t;

  sb_t sbq[$];
  int  runs[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event-missing expected event", name);
  endtask

  // Sample k to lane bits: lane j, bit position k.
  function automatic logic [79:0] to_lanes(input logic [79:0] f);
    logic [79:0] q;
    logic [9:0]  smp;
    q = '0;
    for (int k = 0; k < 8; k++) begin
      smp = f[10*k +: 10];
      for (int j = 0; j < 10; j++) q[8*j+k] = smp[j];
    end
    return q;
  endfunction

  // Capture-side realign: rebuild the 80-bit frame from lane bytes.
  function automatic logic [79:0] realign(input logic [79:0] q);
    logic [79:0] f;
    logic [7:0]  lane;
    f = '0;
    for (int j = 0; j < 10; j++) begin
      lane = q[8*j +: 8];
      for (int k = 0; k < 8; k++) f[10*k+j] = lane[k];
    end
    return f;
  endfunction

  function automatic logic [79:0] mkframe(input int seed);
    logic [79:0] f;
    for (int k = 0; k < 8; k++) f[10*k +: 10] = 10'(seed * 113 + k * 29 + 7);
    return f;
  endfunction

  // ---- monitor ----
  int          since_rst = 0;
  logic [15:0] exp_uf = '0;
  int          train_run = 0;

  always @(negedge clk_div) begin
    if (!rst_n) begin
      since_rst = 0;
      exp_uf    = '0;
      train_run = 0;
    end else begin
      since_rst++;
      if (since_rst <= 2) begin
        train_run = 0;
        chk("post_reset_blank", {q_is_data, training, q_or, q_data}, '0);
      end else if (q_is_data) begin
        if (train_run > 0) runs.push_back(train_run);
        train_run = 0;
        if (sbq.size() == 0) begin
          fail_now("unexpected_data_frame");
        end else begin
          sb_t e;
          e = sbq.pop_front();
          chk("data_lanes", q_data, e.exp_q);
          chk("data_or", 80'(q_or), 80'({8{e.exp_or}}));
          chk("realign", realign(q_data), e.src);
          chk("data_training_flag", 80'(training), 80'(0));
        end
      end else if (training) begin
        train_run++;
        chk("train_lanes", q_data, TRAIN_Q);
        chk("train_or", 80'(q_or), 80'(0));
      end else begin
        if (train_run > 0) runs.push_back(train_run);
        train_run = 0;
        exp_uf = (exp_uf == 16'hFFFF) ? exp_uf : exp_uf + 16'd1;
        chk("idle_lanes", q_data, IDLE_Q);
        chk("idle_or", 80'(q_or), 80'(0));
      end
      chk("underflow_cnt", 80'(underflow_cnt), 80'(exp_uf));
    end
  end

  // ---- stimulus ----
  task automatic push(input logic [79:0] d, input logic o, input logic [79:0] eq);
    bit acc;
    bit done;
    done    = 0;
    s_data  = d;
    s_or    = o;
    s_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      acc = s_ready;
      @(posedge clk_div);
      if (acc) begin
        sbq.push_back('{d, eq, o});
        done = 1;
      end else begin
        @(negedge clk_div);
        #1;
      end
    end
    if (!done) fail_now("push_timeout");
    @(negedge clk_div);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic pulse_train(input logic [7:0] len);
    train_req = 1'b1;
    train_len = len;
    @(posedge clk_div);
    @(negedge clk_div);
    #1;
    train_req = 1'b0;
  endtask

  task automatic expect_run(input string name, input int n);
    int got;
    bit seen;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (runs.size() > 0) seen = 1;
      else @(negedge clk_div);
    end
    if (!seen) fail_now(name);
    else begin
      got = runs.pop_front();
      chk(name, 80'(got), 80'(n));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_div);
    #1;
  endtask

  logic [79:0] onehot;
  bit          sat_seen;

  initial begin
    rst_n = 1'b1; s_valid = 1'b0; s_data = '0; s_or = 1'b0;
    train_req = 1'b0; train_len = 8'd0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_q_data", q_data, '0);
    chk("reset_flags", {q_or, q_is_data, training, s_ready}, '0);
    chk("reset_underflow", 80'(underflow_cnt), 80'(0));
    repeat (3) @(negedge clk_div);
    #1 rst_n = 1'b1;

    // Fill FIFO during initial training; 5th frame waits for DATA pops.
    for (int i = 0; i < 4; i++) push(mkframe(i), i[0], to_lanes(mkframe(i)));
    chk("full_s_ready", 80'(s_ready), 80'(0));
    chk("full_training", 80'(training), 80'(1));
    push(mkframe(4), 1'b1, to_lanes(mkframe(4)));
    idle(10);
    expect_run("initial_train_len", 64);

    // Hand-computed lane patterns.
    onehot = '0;
    for (int k = 0; k < 8; k++) onehot[10*k+k] = 1'b1;
    push(onehot, 1'b1, 80'h00008040201008040201);
    push({8{10'h3FF}}, 1'b0, {10{8'hFF}});
    push({70'd0, 10'h3FF}, 1'b1, {10{8'h01}});
    push({8{10'h200}}, 1'b0, IDLE_Q);
    idle(6);

    // Continuous traffic interrupted by training requests.
    fork
      for (int i = 0; i < 10; i++) push(mkframe(10 + i), i[1], to_lanes(mkframe(10 + i)));
      begin idle(3); pulse_train(8'd3); end
    join
    idle(8);
    expect_run("train_req_len3", 3);
    fork
      for (int i = 0; i < 6; i++) push(mkframe(30 + i), i[0], to_lanes(mkframe(30 + i)));
      begin idle(2); pulse_train(8'd0); end
    join
    idle(8);
    expect_run("train_req_len0", 1);
    chk("drained", 80'(sbq.size()), 80'(0));

    // Long idle run until the underflow counter saturates.
    sat_seen = 0;
    for (int i = 0; i < 70000 && !sat_seen; i++) begin
      @(negedge clk_div);
      if (underflow_cnt == 16'hFFFF) sat_seen = 1;
    end
    if (!sat_seen) fail_now("underflow_saturate");
    idle(5);
    chk("underflow_hold", 80'(underflow_cnt), 80'(16'hFFFF));

    // Mid-stream reset with frames buffered during training.
    pulse_train(8'd20);
    push(mkframe(50), 1'b0, to_lanes(mkframe(50)));
    push(mkframe(51), 1'b1, to_lanes(mkframe(51)));
    @(posedge clk_div);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_q_data", q_data, '0);
    chk("midreset_flags", {q_or, q_is_data, training, s_ready}, '0);
    chk("midreset_underflow", 80'(underflow_cnt), 80'(0));
    sbq.delete();
    runs.delete();
    @(negedge clk_div);
    #1 rst_n = 1'b1;
    idle(80);
    expect_run("retrain_len", 64);
    chk("no_data_after_reset", 80'(sbq.size()), 80'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
